// File: rtl/imem_pkg.sv
// imem_pkg -- shared constants and FSM encoding for the instruction-memory
// responder.
//   IMEM_ADDR_W / IMEM_DATA_W : default word-address and instruction widths
//   NOP                        : instruction returned for unprogrammed words
//   state_t                    : responder FSM state encoding
package imem_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,  // no response held
    RESP = 1'b1   // response held on outputs
  } state_t;

endpackage

// File: rtl/imem_array.sv
// imem_array -- instruction storage.
//   One write port and one synchronous read port. Each word has a
//   written-bit so that reads of never-programmed words can be flagged.
// Ports:
//   clk, rst_n          clock / async active-low reset (clears written-bits
//                       and the read register; storage is not reset)
//   wr_en/wr_addr/wr_data  program-load write port
//   rd_en/rd_addr       read strobe and address; result registered
//   rd_ins/rd_err       registered read result, held while rd_en is low
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_ins,
  output logic              rd_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read samples mem/written before this edge's write lands, so a
  // same-cycle write and read to one address returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      rd_ins  <= '0;
      rd_err  <= 1'b0;
    end else begin
      if (wr_en) written[wr_addr] <= 1'b1;
      if (rd_en) begin
        if (written[rd_addr]) begin
          rd_ins <= mem[rd_addr];
          rd_err <= 1'b0;
        end else begin
          rd_ins <= DATA_W'(NOP);
          rd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder -- single-outstanding instruction fetch responder.
//   Accepts a fetch request, returns the instruction one cycle later and holds
//   it until the fetcher takes it. A new request may be accepted in the same
//   cycle the held response is taken, giving back-to-back throughput.
// Ports:
//   IMEM_clk, IMEM_rst                    clock / async active-low reset
//   IMEM_req_valid/ready/addr             fetch request handshake
//   IMEM_rsp_valid/ready/ins/err          fetch response handshake
//   IMEM_wr_en/wr_addr/wr_data            program-load write port
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              IMEM_clk,
  input  logic              IMEM_rst,
  input  logic              IMEM_req_valid,
  output logic              IMEM_req_ready,
  input  logic [ADDR_W-1:0] IMEM_req_addr,
  output logic              IMEM_rsp_valid,
  input  logic              IMEM_rsp_ready,
  output logic [DATA_W-1:0] IMEM_rsp_ins,
  output logic              IMEM_rsp_err,
  input  logic              IMEM_wr_en,
  input  logic [ADDR_W-1:0] IMEM_wr_addr,
  input  logic [DATA_W-1:0] IMEM_wr_data
);

  state_t state, state_nxt;
  logic   accept;
  logic   wr_en_q;

  always_ff @(posedge IMEM_clk or negedge IMEM_rst) begin
    if (!IMEM_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    IMEM_req_ready = 1'b0;
    case (state)
      IDLE: IMEM_req_ready = 1'b1;
      RESP: IMEM_req_ready = IMEM_rsp_ready;
      default: IMEM_req_ready = 1'b0;
    endcase
    // Nothing is accepted while reset is held.
    if (!IMEM_rst) IMEM_req_ready = 1'b0;

    case (state)
      IDLE: if (accept) state_nxt = RESP;
      RESP: if (IMEM_rsp_ready) state_nxt = accept ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept         = IMEM_req_valid && IMEM_req_ready;
  assign IMEM_rsp_valid = (state == RESP);
  assign wr_en_q        = IMEM_wr_en && IMEM_rst;

  imem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (IMEM_clk),
    .rst_n   (IMEM_rst),
    .wr_en   (wr_en_q),
    .wr_addr (IMEM_wr_addr),
    .wr_data (IMEM_wr_data),
    .rd_en   (accept),
    .rd_addr (IMEM_req_addr),
    .rd_ins  (IMEM_rsp_ins),
    .rd_err  (IMEM_rsp_err)
  );

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder -- directed, table-driven bench for imem_responder.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_ins;
  logic        rsp_err;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] A0 = 32'hA0A0_0000;
  localparam logic [31:0] A1 = 32'hA1A1_0001;
  localparam logic [31:0] A2 = 32'hA2A2_0002;

  imem_responder dut (
    .IMEM_clk       (clk),
    .IMEM_rst       (rst),
    .IMEM_req_valid (req_valid),
    .IMEM_req_ready (req_ready),
    .IMEM_req_addr  (req_addr),
    .IMEM_rsp_valid (rsp_valid),
    .IMEM_rsp_ready (rsp_ready),
    .IMEM_rsp_ins   (rsp_ins),
    .IMEM_rsp_err   (rsp_err),
    .IMEM_wr_en     (wr_en),
    .IMEM_wr_addr   (wr_addr),
    .IMEM_wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [5:0]  ra;
    logic        rr;
    logic        e_rdy;  // req_ready before the edge
    logic        e_vld;  // rsp_valid after the edge
    logic        chk;    // compare ins/err after the edge
    logic [31:0] e_ins;
    logic        e_err;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic wen, logic [5:0] wa, logic [31:0] wd,
                              logic rv, logic [5:0] ra, logic rr,
                              logic e_rdy, logic e_vld, logic chk,
                              logic [31:0] e_ins, logic e_err);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk = chk; v.e_ins = e_ins;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            wen wa  wd            rv ra  rr  rdy vld chk ins           err
    vecs[0]  = mk(1, 0,  A0,           1, 5,  1,  1,  1,  1,  NOP_I,        1);
    vecs[1]  = mk(1, 3,  32'h00500093, 0, 0,  1,  1,  0,  0,  0,            0);
    vecs[2]  = mk(1, 1,  A1,           1, 3,  1,  1,  1,  1,  32'h00500093, 0);
    vecs[3]  = mk(1, 3,  32'hDEADBEEF, 1, 0,  0,  0,  1,  1,  32'h00500093, 0);
    vecs[4]  = mk(1, 3,  32'hDEADBEEF, 1, 0,  0,  0,  1,  1,  32'h00500093, 0);
    vecs[5]  = mk(1, 3,  32'hDEADBEEF, 1, 0,  0,  0,  1,  1,  32'h00500093, 0);
    vecs[6]  = mk(1, 3,  32'hDEADBEEF, 1, 0,  0,  0,  1,  1,  32'h00500093, 0);
    vecs[7]  = mk(1, 2,  A2,           1, 0,  1,  1,  1,  1,  A0,           0);
    vecs[8]  = mk(0, 0,  0,            1, 1,  1,  1,  1,  1,  A1,           0);
    vecs[9]  = mk(0, 0,  0,            1, 2,  1,  1,  1,  1,  A2,           0);
    vecs[10] = mk(0, 0,  0,            1, 3,  1,  1,  1,  1,  32'hDEADBEEF, 0);
    vecs[11] = mk(1, 7,  32'h22222222, 0, 0,  1,  1,  0,  0,  0,            0);
    vecs[12] = mk(1, 7,  32'h11111111, 1, 7,  1,  1,  1,  1,  32'h22222222, 0);
    vecs[13] = mk(0, 0,  0,            1, 7,  1,  1,  1,  1,  32'h11111111, 0);
    vecs[14] = mk(0, 0,  0,            1, 63, 1,  1,  1,  1,  NOP_I,        1);
    vecs[15] = mk(0, 0,  0,            0, 0,  1,  1,  0,  0,  0,            0);
    vecs[16] = mk(0, 0,  0,            1, 4,  0,  1,  1,  1,  NOP_I,        1);
    vecs[17] = mk(0, 0,  0,            0, 0,  0,  0,  1,  1,  NOP_I,        1);
    vecs[18] = mk(0, 0,  0,            0, 0,  1,  1,  0,  0,  0,            0);

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'(1'b0));
    check("reset rsp_ins",   rsp_ins, 32'h0);
    check("reset rsp_err",   32'(rsp_err), 32'(1'b0));
    check("reset req_ready", 32'(req_ready), 32'(1'b0));

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wen; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      req_valid = vecs[i].rv; req_addr = vecs[i].ra; rsp_ready = vecs[i].rr;
      #1;
      check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_vld));
      if (vecs[i].chk) begin
        check($sformatf("vec%0d rsp_ins", i), rsp_ins, vecs[i].e_ins);
        check($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
      end
    end

    // Reset while a response is held: outputs drop without a clock edge.
    @(negedge clk);
    wr_en = 1'b0; req_valid = 1'b1; req_addr = 6'd0; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset rsp_valid", 32'(rsp_valid), 32'(1'b1));
    check("pre-reset rsp_ins",   rsp_ins, A0);
    #1;
    rst = 1'b0;
    #1;
    check("async rst rsp_valid", 32'(rsp_valid), 32'(1'b0));
    check("async rst rsp_ins",   rsp_ins, 32'h0);
    check("async rst rsp_err",   32'(rsp_err), 32'(1'b0));
    check("async rst req_ready", 32'(req_ready), 32'(1'b0));

    // Traffic during reset must be ignored.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hCAFE_F00D;
    req_valid = 1'b1; req_addr = 6'd5; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in-reset rsp_valid", 32'(rsp_valid), 32'(1'b0));

    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset no resume", 32'(rsp_valid), 32'(1'b0));

    @(negedge clk);
    req_valid = 1'b1; req_addr = 6'd0;
    @(posedge clk);
    #1;
    check("post-reset addr0 valid", 32'(rsp_valid), 32'(1'b1));
    check("post-reset addr0 ins",   rsp_ins, NOP_I);
    check("post-reset addr0 err",   32'(rsp_err), 32'(1'b1));

    @(negedge clk);
    req_addr = 6'd5;
    @(posedge clk);
    #1;
    check("reset-write addr5 ins", rsp_ins, NOP_I);
    check("reset-write addr5 err", 32'(rsp_err), 32'(1'b1));

    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words.
REQ-002 SHALL have parameter ADDR_W, default 6, word-address width (log2 DEPTH).
REQ-003 SHALL have parameter DATA_W, default 32, instruction width.
REQ-004 SHALL have port IMEM_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port IMEM_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IMEM_req_valid  input  1  fetch request present.
REQ-007 SHALL have port IMEM_req_ready  output  1  request can be accepted this cycle.
REQ-008 SHALL have port IMEM_req_addr  input  ADDR_W  word address of requested instruction.
REQ-009 SHALL have port IMEM_rsp_valid  output  1  response holds valid instruction.
REQ-010 SHALL have port IMEM_rsp_ready  input  1  fetcher accepts response this cycle.
REQ-011 SHALL have port IMEM_rsp_ins  output  DATA_W  returned instruction.
REQ-012 SHALL have port IMEM_rsp_err  output  1  addressed word never programmed since reset.
REQ-013 SHALL have port IMEM_wr_en  input  1  program-load write strobe.
REQ-014 SHALL have port IMEM_wr_addr  input  ADDR_W  program-load word address.
REQ-015 SHALL have port IMEM_wr_data  input  DATA_W  program-load data.

Function
REQ-016 SHALL implement FSM states IDLE (no response held) and RESP (response held on outputs).
REQ-017 SHALL drive IMEM_req_ready = 1 in IDLE, and = IMEM_rsp_ready in RESP (one outstanding response, back-to-back throughput).
REQ-018 SHALL accept a request when IMEM_req_valid && IMEM_req_ready; accepted request -> RESP next cycle with IMEM_rsp_valid = 1 (latency exactly 1 cycle).
REQ-019 SHALL return mem[addr] on IMEM_rsp_ins with IMEM_rsp_err = 0 when addr's written-bit is set; otherwise IMEM_rsp_ins = 32'h0000_0013 (NOP), IMEM_rsp_err = 1.
REQ-020 SHALL hold IMEM_rsp_ins, IMEM_rsp_err, IMEM_rsp_valid stable while IMEM_rsp_valid && !IMEM_rsp_ready, regardless of writes.
REQ-021 SHALL, in RESP with IMEM_rsp_ready = 1: no new request -> IDLE, rsp_valid = 0 next cycle; new request accepted -> stay RESP with new data next cycle.
REQ-022 SHALL perform write mem[wr_addr] <= wr_data and set written-bit on any cycle IMEM_wr_en = 1, independent of FSM state.
REQ-023 SHALL, on simultaneous write and accepted read to same address, return the OLD contents and OLD written-bit (read-before-write).
REQ-024 SHALL ignore IMEM_req_addr and IMEM_req_valid when request not accepted (no side effects).

Reset
REQ-025 SHALL, on IMEM_rst = 0, immediately force state IDLE, IMEM_rsp_valid = 0, IMEM_rsp_ins = 0, IMEM_rsp_err = 0, all written-bits = 0.
REQ-026 SHALL not reset the instruction storage array contents.
REQ-027 SHALL drop any held response on reset mid-operation; no response resumes after release.
REQ-028 SHALL ignore writes and requests while IMEM_rst = 0; IMEM_req_ready SHALL be 0 during reset.

Structure
REQ-029 SHALL place ADDR_W/DATA_W defaults, NOP constant 32'h0000_0013 and FSM state encoding in shared package imem_pkg.
REQ-030 SHALL isolate storage in sub-module imem_array (1 write port, 1 synchronous read port, per-word written-bit vector).

Verification
REQ-031 SHALL verify: after reset, request addr 5 unprogrammed -> next cycle rsp_valid = 1, rsp_ins = 32'h0000_0013, rsp_err = 1.
REQ-032 SHALL verify: write addr 3 = 32'h00500093, then request addr 3 -> rsp_ins = 32'h00500093, rsp_err = 0, one cycle later.
REQ-033 SHALL verify: rsp_ready = 0 for 4 cycles with write of 32'hDEADBEEF to held address -> rsp_ins unchanged, req_ready = 0 throughout.
REQ-034 SHALL verify: rsp_ready = 1, requests addr 0,1,2 on consecutive cycles -> responses on consecutive cycles in order, no bubbles.
REQ-035 SHALL verify: same-cycle write addr 7 = 32'h11111111 (old 32'h22222222) and read addr 7 -> returns 32'h22222222; next read returns 32'h11111111.
REQ-036 SHALL verify: assert IMEM_rst while rsp_valid = 1 -> rsp_valid = 0 without clock edge; prior programmed word reads rsp_err = 1 after release.
